// File: rtl/lc_3_io_ctrl.sv
// LC-3 console I/O: decodes KBSR/KBDR/DSR/DDR, latches keyboard bytes, sends display bytes as 8N1 UART.
// Reads: 1-cycle registered. A DDR write is accepted only while DSR ready; other DDR writes are dropped.
module lc_3_io_ctrl #(
   parameter int WORD         = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [WORD-1:0] addr,
   input  logic            mem_en,
   input  logic            r_w,
   input  logic [WORD-1:0] data_in,
   output logic [WORD-1:0] data_out,
   output logic            io_hit,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            tx,
   output logic            kb_int,
   output logic            dsp_int
);

   localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

   tx_state_e       state_q;
   logic [15:0]     baud_q;
   logic [2:0]      bit_q;
   logic            tx_q;
   logic            dsr_rdy_q;
   logic            dsp_ie_q;
   logic [7:0]      ddr_q;
   logic            kb_rdy_q;
   logic            kb_ie_q;
   logic [7:0]      kbdr_q;
   logic [WORD-1:0] data_out_q;
   logic [WORD-1:0] data_out_d;

   logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
   logic rd_en, wr_en, kbdr_rd, ddr_wr_ok, baud_done;
   logic unused_data_in;

   assign hit_kbsr  = (addr == WORD'(16'hFE00));
   assign hit_kbdr  = (addr == WORD'(16'hFE02));
   assign hit_dsr   = (addr == WORD'(16'hFE04));
   assign hit_ddr   = (addr == WORD'(16'hFE06));
   assign io_hit    = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

   assign rd_en     = mem_en & io_hit & ~r_w;
   assign wr_en     = mem_en & io_hit & r_w;
   assign kbdr_rd   = rd_en & hit_kbdr;
   assign ddr_wr_ok = wr_en & hit_ddr & dsr_rdy_q;
   assign baud_done = (baud_q == BAUD_MAX);

   assign unused_data_in = ^{data_in[WORD-1:15], data_in[13:8]};

   always_comb begin
      data_out_d = data_out_q;
      if (rd_en) begin
         data_out_d = '0;
         if (hit_kbsr) begin
            data_out_d[15] = kb_rdy_q;
            data_out_d[14] = kb_ie_q;
         end else if (hit_kbdr) begin
            data_out_d[7:0] = kbdr_q;
         end else if (hit_dsr) begin
            data_out_d[15] = dsr_rdy_q;
            data_out_d[14] = dsp_ie_q;
         end else begin
            data_out_d[7:0] = ddr_q;
         end
      end
   end

   // A new byte wins over a same-edge KBDR read, so ready survives the collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         kb_rdy_q   <= 1'b0;
         kb_ie_q    <= 1'b0;
         kbdr_q     <= 8'h00;
         dsp_ie_q   <= 1'b0;
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
         if (rx_valid) begin
            kb_rdy_q <= 1'b1;
            kbdr_q   <= rx_data;
         end else if (kbdr_rd) begin
            kb_rdy_q <= 1'b0;
         end
         if (wr_en && hit_kbsr) kb_ie_q  <= data_in[14];
         if (wr_en && hit_dsr)  dsp_ie_q <= data_in[14];
      end
   end

   // tx lags the state by one edge; ready is re-armed from IDLE so it lines up with the end of the stop bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         baud_q    <= 16'd0;
         bit_q     <= 3'd0;
         tx_q      <= 1'b1;
         dsr_rdy_q <= 1'b1;
         ddr_q     <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q      <= 1'b1;
               dsr_rdy_q <= 1'b1;
               if (ddr_wr_ok) begin
                  ddr_q     <= data_in[7:0];
                  dsr_rdy_q <= 1'b0;
                  baud_q    <= 16'd0;
                  state_q   <= START;
               end
            end
            START: begin
               tx_q <= 1'b0;
               if (baud_done) begin
                  baud_q  <= 16'd0;
                  bit_q   <= 3'd0;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            DATA: begin
               tx_q <= ddr_q[bit_q];
               if (baud_done) begin
                  baud_q <= 16'd0;
                  if (bit_q == 3'd7) state_q <= STOP;
                  else               bit_q   <= bit_q + 3'd1;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            default: begin
               tx_q <= 1'b1;
               if (baud_done) begin
                  baud_q  <= 16'd0;
                  bit_q   <= 3'd0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
         endcase
      end
   end

   assign data_out = data_out_q;
   assign tx       = tx_q;
   assign kb_int   = kb_rdy_q & kb_ie_q;
   assign dsp_int  = dsr_rdy_q & dsp_ie_q;

endmodule

// File: tb/tb_lc_3_io_ctrl.sv
// Bench for lc_3_io_ctrl: read data and tx levels are queued as expectations and compared on output.
module tb_lc_3_io_ctrl;

   localparam int CPB = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] addr, data_in, data_out;
   logic        mem_en, r_w, io_hit;
   logic [7:0]  rx_data;
   logic        rx_valid, tx, kb_int, dsp_int;

   int n_chk  = 0;
   int n_fail = 0;
   logic [15:0] rd_exp_q[$];
   string       rd_tag_q[$];
   logic        tx_exp_q[$];
   logic [15:0] model_dout;

   lc_3_io_ctrl #(.WORD(16), .CLKS_PER_BIT(CPB)) dut (
      .clock(clock), .reset(reset), .addr(addr), .mem_en(mem_en), .r_w(r_w),
      .data_in(data_in), .data_out(data_out), .io_hit(io_hit),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx(tx),
      .kb_int(kb_int), .dsp_int(dsp_int)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One bus edge; entered and left at a falling edge.
   task automatic acc(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic rxv, input logic [7:0] rxd, input logic [15:0] exp, input string tag);
      logic do_chk;
      do_chk   = en & ~wr;
      mem_en   = en;
      r_w      = wr;
      addr     = a;
      data_in  = wd;
      rx_valid = rxv;
      rx_data  = rxd;
      if (do_chk) begin
         rd_exp_q.push_back(exp);
         rd_tag_q.push_back(tag);
         model_dout = exp;
      end
      @(posedge clock);
      @(negedge clock);
      mem_en   = 1'b0;
      rx_valid = 1'b0;
      if (do_chk) chk(rd_tag_q.pop_front(), data_out, rd_exp_q.pop_front());
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      acc(1'b1, 1'b0, a, 16'h0, 1'b0, 8'h00, exp, tag);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      acc(1'b1, 1'b1, a, d, 1'b0, 8'h00, 16'h0, "wr");
   endtask

   task automatic rxp(input logic [7:0] b);
      acc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, b, 16'h0, "rx");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic push_frame(input logic [7:0] b);
      logic [9:0] lv;
      lv = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < CPB; j++) tx_exp_q.push_back(lv[i]);
   endtask

   always @(posedge clock) begin
      logic e;
      #2;
      if (tx_exp_q.size() > 0) begin
         e = tx_exp_q.pop_front();
         chk("tx_bit", {15'b0, tx}, {15'b0, e});
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; addr = 16'h0; mem_en = 1'b0; r_w = 1'b0;
      data_in = 16'h0; rx_data = 8'h0; rx_valid = 1'b0; model_dout = 16'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("rst_tx", {15'b0, tx}, 16'h1);
      chk("rst_kb_int", {15'b0, kb_int}, 16'h0);
      chk("rst_dsp_int", {15'b0, dsp_int}, 16'h0);
      chk("rst_dout", data_out, 16'h0);
      rd(16'hFE04, 16'h8000, "rst_dsr");
      rd(16'hFE00, 16'h0000, "rst_kbsr");

      rxp(8'h41);
      rd(16'hFE00, 16'h8000, "kbsr_rdy");
      rd(16'hFE02, 16'h0041, "kbdr_41");
      rd(16'hFE00, 16'h0000, "kbsr_clr");
      wr(16'hFE00, 16'h4000);
      chk("kb_int_no_rdy", {15'b0, kb_int}, 16'h0);
      rxp(8'h41);
      chk("kb_int_set", {15'b0, kb_int}, 16'h1);

      acc(1'b1, 1'b0, 16'hFE02, 16'h0, 1'b1, 8'h61, 16'h0041, "coll_old");
      rd(16'hFE00, 16'hC000, "coll_rdy_kept");
      rd(16'hFE02, 16'h0061, "coll_new");
      rd(16'hFE00, 16'h4000, "coll_rdy_clr");
      chk("kb_int_clr", {15'b0, kb_int}, 16'h0);

      wr(16'hFE06, 16'h0055);
      push_frame(8'h55);
      rd(16'hFE04, 16'h0000, "dsr_busy");
      wr(16'hFE06, 16'h00FF);
      rd(16'hFE06, 16'h0055, "ddr_busy_wr");
      idle(37);
      rd(16'hFE04, 16'h0000, "dsr_last_cyc");
      rd(16'hFE04, 16'h8000, "dsr_done");
      chk("txq_55", 16'(tx_exp_q.size()), 16'h0);
      chk("tx_idle_55", {15'b0, tx}, 16'h1);

      wr(16'hFE04, 16'h4000);
      chk("dsp_int_set", {15'b0, dsp_int}, 16'h1);
      rd(16'hFE04, 16'hC000, "dsr_ie");
      wr(16'hFE06, 16'h00A5);
      chk("dsp_int_busy", {15'b0, dsp_int}, 16'h0);
      idle(9);
      chk("tx_pre_rst", {15'b0, tx}, 16'h0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("tx_post_rst", {15'b0, tx}, 16'h1);
      @(negedge clock);
      reset = 1'b0;
      model_dout = 16'h0;
      rd(16'hFE04, 16'h8000, "dsr_post_rst");
      wr(16'hFE06, 16'h00A5);
      push_frame(8'hA5);
      idle(41);
      chk("txq_a5", 16'(tx_exp_q.size()), 16'h0);
      chk("tx_idle_a5", {15'b0, tx}, 16'h1);
      rd(16'hFE06, 16'h00A5, "ddr_a5");
      rd(16'hFE04, 16'h8000, "dsr_a5_done");

      addr = 16'hFE08;
      #1;
      chk("io_hit_fe08", {15'b0, io_hit}, 16'h0);
      addr = 16'hFE06;
      #1;
      chk("io_hit_fe06", {15'b0, io_hit}, 16'h1);
      acc(1'b1, 1'b0, 16'hFE08, 16'h0, 1'b0, 8'h00, model_dout, "dout_hold");
      chk("txq_end", 16'(tx_exp_q.size()), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
